// File: rtl/btn_event_bank.sv
// Multi-channel button front end: sync, debounce, press/release pulses, held level.
// Optional auto-repeat of press while held: define BTN_AUTOREPEAT_EN.

module btn_event_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press,
  output logic o_release,
  output logic o_held
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HELD, S_REL} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_db;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_p;
  logic [CW-1:0]          w_cnt_inc;
  logic                   w_press_nxt;
  logic                   w_release_nxt;
  logic                   w_held_nxt;
  logic                   w_rep_hit;

  // Reset to all-ones so a button held through reset looks released and re-presses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
  end

  assign w_p       = ~r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (w_p == r_db) begin
      r_cnt <= '0;
    end else if (w_cnt_inc == CW'(DEBOUNCE_CYC)) begin
      r_db  <= w_p;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rcnt;
  logic          r_rfirst;
  logic [RW-1:0] w_rcnt_inc;

  assign w_rcnt_inc = r_rcnt + RW'(1);
  assign w_rep_hit  = (r_state == S_HELD) &&
                      (r_rfirst ? (w_rcnt_inc == RW'(REPEAT_DELAY))
                                : (w_rcnt_inc == RW'(REPEAT_PERIOD)));

  // Outside S_HELD (including S_PULSE) the repeat timer sits cleared and armed for the long first delay.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end else if (r_state != S_HELD) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end else if (w_rep_hit) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b0;
    end else begin
      r_rcnt   <= w_rcnt_inc;
    end
  end
`else
  assign w_rep_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_held_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_db) w_state_nxt = S_PULSE;
      end
      S_PULSE: begin
        w_press_nxt = 1'b1;
        w_held_nxt  = 1'b1;
        w_state_nxt = r_db ? S_HELD : S_REL;
      end
      S_HELD: begin
        w_held_nxt  = 1'b1;
        w_press_nxt = w_rep_hit;
        if (!r_db) w_state_nxt = S_REL;
      end
      S_REL: begin
        w_release_nxt = 1'b1;
        w_state_nxt   = r_db ? S_PULSE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_held    <= 1'b0;
    end else begin
      o_press   <= w_press_nxt;
      o_release <= w_release_nxt;
      o_held    <= w_held_nxt;
    end
  end
endmodule

module btn_event_bank #(
  parameter int N_BTN         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn_n,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_held
);
  if (N_BTN < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_event_bank: illegal parameter value");
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    btn_event_lane #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_btn_n   (i_btn_n[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_held    (o_held[g])
    );
  end
endmodule

// File: doc/btn_event_bank.md
Name: btn_event_bank

Overview:
- Parametrised multi-channel successor to the single-button press-to-pulse FSM.
- Accepts N active-low raw button inputs and provides per channel:
  - metastability synchronisation
  - counter-based debounce
  - a one-cycle press pulse, a one-cycle release pulse, and a level "held" flag
- Sits between board pins and UI/control logic; every output is registered and synchronous to clk.

Parameters:
- N_BTN, 4, number of independent button channels (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- DEBOUNCE_CYC, 4, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (>=1).
- REPEAT_DELAY, 8, cycles from a press pulse to the first auto-repeat pulse (only used with BTN_AUTOREPEAT_EN; >=1).
- REPEAT_PERIOD, 4, cycles between subsequent auto-repeat pulses (only used with BTN_AUTOREPEAT_EN; >=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_n  input  N_BTN  raw active-low buttons; bit i = channel i; asynchronous to clk.
- press  output  N_BTN  one-cycle active-high pulse per accepted press (plus repeats if enabled).
- release  output  N_BTN  one-cycle active-high pulse per accepted release.
- held  output  N_BTN  level: 1 while debounced state is pressed.

Behaviour:
- Reset values, while rst=1, all channels:
  - synchroniser flops = 1 (released)
  - debounce counter = 0
  - debounced state = released
  - FSM = S_IDLE
  - press = release = held = 0
- Per-channel synchroniser: SYNC_STAGES flops; output s_n = last stage. Internal active-high pressed level p = ~s_n.
- Debounce:
  - Counter width $clog2(DEBOUNCE_CYC+1).
  - Each edge:
    - if p == db, counter <= 0
    - else counter <= counter+1
    - when counter+1 == DEBOUNCE_CYC: db <= p and counter <= 0
  - A glitch shorter than DEBOUNCE_CYC cycles never changes db.
  - Counter never wraps.
- Per-channel FSM (registered outputs, default press=release=0 every cycle):
  - S_IDLE: db=1 -> S_PULSE.
  - S_PULSE: press<=1.
    - db=1 -> S_HELD
    - db=0 -> S_REL (press of exactly DEBOUNCE_CYC-length still yields press then release)
  - S_HELD: db=0 -> S_REL.
  - S_REL: release<=1; then:
    - db=1 -> S_PULSE
    - db=0 -> S_IDLE
- held <= 1 in S_PULSE and S_HELD; 0 otherwise.
- Latency: a clean btn_n falling edge sampled at edge 0 gives press=1 in the cycle after edge SYNC_STAGES+DEBOUNCE_CYC+1. Release latency is identical. Defaults give 7 cycles.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- press and release of one channel are never high in the same cycle.
- Reset mid-operation:
  - all outputs drop to 0 asynchronously
  - a button still held when rst deasserts is treated as a new press: press pulse after the full latency
  - no release is emitted for the interrupted press

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined:
  - A per-channel repeat counter, width sized for max(REPEAT_DELAY, REPEAT_PERIOD), is cleared on S_PULSE.
  - While in S_HELD it counts. Reaching REPEAT_DELAY (first repeat) or REPEAT_PERIOD (later repeats) emits a one-cycle press and reloads.
  - Leaving S_HELD clears it. Repeat pulses never coincide with release.
- Undefined: no repeat logic is synthesised. press fires exactly once per debounced press. REPEAT_* parameters are ignored.

Test Plan:
- Defaults. Reset, then btn_n[0] 1->0 held 20 cycles, then 1 -> press[0] high exactly 1 cycle at cycle 7 after the fall; held[0] high from that cycle until release; release[0] high 1 cycle 7 cycles after the rise; other channels stay 0.
- btn_n[1] low for 3 cycles (glitch < DEBOUNCE_CYC) -> no press, release or held on any channel.
- btn_n[0] and btn_n[3] fall in the same cycle -> press[0] and press[3] both high in the same single cycle; btn_n[3] released 5 cycles later -> release[3] only.
- Hold btn_n[2]=0, assert rst for 3 cycles mid-hold, keep button low after rst drops -> outputs 0 during rst; press[2] pulses again 7 cycles after rst deassert; no release pulse.
- Bouncy press: btn_n[0] toggles every cycle for 10 cycles, then stable low -> exactly one press[0], 7 cycles after the final stable-low edge.
- BTN_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, btn_n[0] held 30 cycles -> press[0] at the initial cycle T, then T+8, T+12, T+16, ...; repeats stop on release; single release pulse.
